// File: rtl/pc_pkg.sv
// Shared constants and types for the program-counter sequencer.
// Optional build macro: PC_STACK_GUARD_EN.
package pc_pkg;

    localparam int PC_W      = 11;
    localparam int STK_DEPTH = 16;
    localparam int DEPTH_W   = $clog2(STK_DEPTH + 1);

    localparam logic [PC_W-1:0] RESET_VEC = 11'h000;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_stk_depth_ctr.sv
// Return-stack depth tracker with sticky overflow/underflow flags.
// PC_STACK_GUARD_EN gates strobes that would over/underflow the stack.
module stk_depth_ctr
    import pc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               push_req,
    input  logic               pop_req,
    output logic               push,
    output logic               pop,
    output logic [DEPTH_W-1:0] depth,
    output logic               ovf,
    output logic               unf
);

    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               full, empty;

    assign full  = (depth_q == DEPTH_W'(STK_DEPTH));
    assign empty = (depth_q == '0);

`ifdef PC_STACK_GUARD_EN
    assign push = push_req && !full;
    assign pop  = pop_req && !empty;
`else
    assign push = push_req;
    assign pop  = pop_req;
`endif

    always_comb begin
        depth_d = depth_q;
        ovf_d   = ovf_q || (push_req && full);
        unf_d   = unf_q || (pop_req && empty);
        if (push_req && !full) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (pop_req && !empty) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign depth = depth_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer feeding the return-address stack.
// PC_STACK_GUARD_EN: blocked underflow returns go to RESET_VEC.
module pc_sequencer
    import pc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               jump,
    input  logic               call,
    input  logic               ret,
    input  logic               skip,
    input  logic [PC_W-1:0]    target,
    input  logic [PC_W-1:0]    stack_out,
    output logic [PC_W-1:0]    pc,
    output logic               flush,
    output logic               push,
    output logic               pop,
    output logic [PC_W-1:0]    stack_in,
    output logic [DEPTH_W-1:0] depth,
    output logic               stk_ovf,
    output logic               stk_unf
);

    seq_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc, ret_pc;
    logic            run, push_req, pop_req;

    assign pc_inc   = pc_q + PC_W'(1);
    assign run      = (state_q == RUN) && !stall;
    assign push_req = run && call && !ret;
    assign pop_req  = run && ret;

    stk_depth_ctr u_depth (
        .clk      (clk),
        .reset    (reset),
        .push_req (push_req),
        .pop_req  (pop_req),
        .push     (push),
        .pop      (pop),
        .depth    (depth),
        .ovf      (stk_ovf),
        .unf      (stk_unf)
    );

`ifdef PC_STACK_GUARD_EN
    // pop is only dropped here when the stack is empty
    assign ret_pc = pop ? stack_out : RESET_VEC;
`else
    assign ret_pc = stack_out;
`endif

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (!stall) begin
            if (state_q == FLUSH) begin
                pc_d    = pc_inc;
                state_d = RUN;
            end else if (ret) begin
                pc_d    = ret_pc;
                state_d = FLUSH;
            end else if (call || jump) begin
                pc_d    = target;
                state_d = FLUSH;
            end else if (skip) begin
                pc_d    = pc_inc;
                state_d = FLUSH;
            end else begin
                pc_d    = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_VEC;
            state_q <= FLUSH;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    assign pc       = pc_q;
    assign stack_in = pc_q;
    assign flush    = (state_q == FLUSH);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer; honours PC_STACK_GUARD_EN.
module tb_pc_sequencer;

`ifdef PC_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, stall, jump, call, ret, skip;
    logic [10:0] target, stack_out;
    logic [10:0] pc, stack_in;
    logic        flush, push, pop;
    logic [4:0]  depth;
    logic        stk_ovf, stk_unf;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [10:0] pc;
        logic        fl;
        logic [4:0]  dp;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    pc_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .jump      (jump),
        .call      (call),
        .ret       (ret),
        .skip      (skip),
        .target    (target),
        .stack_out (stack_out),
        .pc        (pc),
        .flush     (flush),
        .push      (push),
        .pop       (pop),
        .stack_in  (stack_in),
        .depth     (depth),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic [10:0] p, logic f, logic [4:0] d);
        exp_t r;
        r.pc = p;
        r.fl = f;
        r.dp = d;
        return r;
    endfunction

    task automatic clr();
        stall = 0; jump = 0; call = 0; ret = 0; skip = 0;
        target = '0; stack_out = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clr();
        call = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (pc !== 11'h000) begin n_err++; $display("FAIL rst_pc got=%h exp=000", pc); end
        n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL rst_flush got=%b exp=1", flush); end
        n_cmp++; if (push !== 1'b0 || pop !== 1'b0) begin n_err++; $display("FAIL rst_strobes got=%b%b exp=00", push, pop); end
        n_cmp++; if ({depth, stk_ovf, stk_unf} !== 7'd0) begin n_err++; $display("FAIL rst_depth got=%h exp=0", {depth, stk_ovf, stk_unf}); end
        @(negedge clk);
        clr();
        reset = 1'b1;
        sb.push_back(mk(11'h000, 1, 0));
        sb.push_back(mk(11'h001, 0, 0));
        sb.push_back(mk(11'h002, 0, 0));
        sb.push_back(mk(11'h003, 0, 0));
        while (sb.size() > 0) begin
            #1;
            e = sb.pop_front();
            n_cmp++; if (pc !== e.pc || flush !== e.fl || depth !== e.dp) begin
                n_err++; $display("FAIL rst_seq got=%h/%b/%0d exp=%h/%b/%0d", pc, flush, depth, e.pc, e.fl, e.dp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_call();
        @(negedge clk);
        #1;
        n_cmp++; if (pc !== 11'h005) begin n_err++; $display("FAIL call_pre got=%h exp=005", pc); end
        call = 1; target = 11'h040;
        #1;
        n_cmp++; if ({push, pop} !== 2'b10) begin n_err++; $display("FAIL call_push got=%b%b exp=10", push, pop); end
        n_cmp++; if (stack_in !== 11'h005) begin n_err++; $display("FAIL call_sin got=%h exp=005", stack_in); end
        sb.push_back(mk(11'h040, 1, 1));
        sb.push_back(mk(11'h041, 0, 1));
        @(negedge clk);
        #1;
        e = sb.pop_front();
        n_cmp++; if (pc !== e.pc || flush !== e.fl || depth !== e.dp) begin
            n_err++; $display("FAIL call_redir got=%h/%b/%0d exp=%h/%b/%0d", pc, flush, depth, e.pc, e.fl, e.dp);
        end
        n_cmp++; if (push !== 1'b0) begin n_err++; $display("FAIL call_flushgate got=%b exp=0", push); end
        clr();
        @(negedge clk);
        #1;
        e = sb.pop_front();
        n_cmp++; if (pc !== e.pc || flush !== e.fl || depth !== e.dp) begin
            n_err++; $display("FAIL call_run got=%h/%b/%0d exp=%h/%b/%0d", pc, flush, depth, e.pc, e.fl, e.dp);
        end
    endtask

    task automatic test_ret();
        call = 1; target = 11'h3FF; ret = 1; stack_out = 11'h005;
        #1;
        n_cmp++; if ({push, pop} !== 2'b01) begin n_err++; $display("FAIL ret_pop got=%b%b exp=01", push, pop); end
        sb.push_back(mk(11'h005, 1, 0));
        sb.push_back(mk(11'h006, 0, 0));
        while (sb.size() > 0) begin
            @(negedge clk);
            clr();
            #1;
            e = sb.pop_front();
            n_cmp++; if (pc !== e.pc || flush !== e.fl || depth !== e.dp) begin
                n_err++; $display("FAIL ret_seq got=%h/%b/%0d exp=%h/%b/%0d", pc, flush, depth, e.pc, e.fl, e.dp);
            end
        end
    endtask

    task automatic test_jump_wrap();
        jump = 1; skip = 1; target = 11'h7FE;
        #1;
        n_cmp++; if ({push, pop} !== 2'b00) begin n_err++; $display("FAIL jmp_strobe got=%b%b exp=00", push, pop); end
        sb.push_back(mk(11'h7FE, 1, 0));
        sb.push_back(mk(11'h7FF, 0, 0));
        sb.push_back(mk(11'h000, 0, 0));
        while (sb.size() > 0) begin
            @(negedge clk);
            clr();
            #1;
            e = sb.pop_front();
            n_cmp++; if (pc !== e.pc || flush !== e.fl) begin
                n_err++; $display("FAIL jmp_seq got=%h/%b exp=%h/%b", pc, flush, e.pc, e.fl);
            end
        end
    endtask

    task automatic test_skip_stall();
        repeat (16) @(negedge clk);
        #1;
        n_cmp++; if (pc !== 11'h010) begin n_err++; $display("FAIL skip_pre got=%h exp=010", pc); end
        skip = 1;
        sb.push_back(mk(11'h011, 1, 0));
        @(negedge clk);
        clr();
        stall = 1; call = 1; ret = 1; target = 11'h123;
        #1;
        e = sb.pop_front();
        n_cmp++; if (pc !== e.pc || flush !== e.fl) begin n_err++; $display("FAIL skip_redir got=%h/%b exp=%h/%b", pc, flush, e.pc, e.fl); end
        for (int k = 0; k < 3; k++) begin
            sb.push_back(mk(11'h011, 1, 0));
            @(negedge clk);
            #1;
            e = sb.pop_front();
            n_cmp++; if (pc !== e.pc || flush !== e.fl || {push, pop} !== 2'b00) begin
                n_err++; $display("FAIL stall_flush got=%h/%b/%b%b exp=%h/%b/00", pc, flush, push, pop, e.pc, e.fl);
            end
        end
        clr();
        sb.push_back(mk(11'h012, 0, 0));
        @(negedge clk);
        stall = 1; call = 1; ret = 1; target = 11'h123;
        #1;
        e = sb.pop_front();
        n_cmp++; if (pc !== e.pc || flush !== e.fl) begin n_err++; $display("FAIL skip_run got=%h/%b exp=%h/%b", pc, flush, e.pc, e.fl); end
        n_cmp++; if ({push, pop} !== 2'b00) begin n_err++; $display("FAIL stall_run_strb got=%b%b exp=00", push, pop); end
        sb.push_back(mk(11'h012, 0, 0));
        @(negedge clk);
        #1;
        e = sb.pop_front();
        n_cmp++; if (pc !== e.pc || flush !== e.fl || depth !== e.dp) begin
            n_err++; $display("FAIL stall_run got=%h/%b/%0d exp=%h/%b/%0d", pc, flush, depth, e.pc, e.fl, e.dp);
        end
        clr();
        @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [10:0] ra;
        logic [4:0]  dexp;
        logic        pexp;
        ra = 11'h013;
        for (int i = 0; i < 17; i++) begin
            call = 1; target = 11'h100 + 11'(i);
            pexp = (i < 16) ? 1'b1 : !GUARD;
            #1;
            n_cmp++; if (push !== pexp || stack_in !== ra) begin
                n_err++; $display("FAIL ovf_push%0d got=%b/%h exp=%b/%h", i, push, stack_in, pexp, ra);
            end
            dexp = (i < 16) ? 5'(i + 1) : 5'd16;
            sb.push_back(mk(11'h100 + 11'(i), 1, dexp));
            sb.push_back(mk(11'h101 + 11'(i), 0, dexp));
            @(negedge clk);
            clr();
            #1;
            e = sb.pop_front();
            n_cmp++; if (pc !== e.pc || flush !== e.fl || depth !== e.dp) begin
                n_err++; $display("FAIL ovf_redir%0d got=%h/%b/%0d exp=%h/%b/%0d", i, pc, flush, depth, e.pc, e.fl, e.dp);
            end
            n_cmp++; if (stk_ovf !== (i == 16)) begin n_err++; $display("FAIL ovf_flag%0d got=%b exp=%b", i, stk_ovf, i == 16); end
            @(negedge clk);
            #1;
            e = sb.pop_front();
            n_cmp++; if (pc !== e.pc || flush !== e.fl) begin
                n_err++; $display("FAIL ovf_run%0d got=%h/%b exp=%h/%b", i, pc, flush, e.pc, e.fl);
            end
            ra = 11'h101 + 11'(i);
        end
    endtask

    task automatic test_underflow_reset();
        logic [10:0] pexp_pc;
        logic        pexp;
        for (int j = 0; j < 17; j++) begin
            ret = 1; stack_out = 11'h200 + 11'(j);
            pexp = (j < 16) ? 1'b1 : !GUARD;
            #1;
            n_cmp++; if (pop !== pexp || push !== 1'b0) begin
                n_err++; $display("FAIL unf_pop%0d got=%b%b exp=0%b", j, push, pop, pexp);
            end
            pexp_pc = (j == 16 && GUARD) ? 11'h000 : 11'h200 + 11'(j);
            sb.push_back(mk(pexp_pc, 1, (j < 16) ? 5'(15 - j) : 5'd0));
            @(negedge clk);
            clr();
            #1;
            e = sb.pop_front();
            n_cmp++; if (pc !== e.pc || flush !== e.fl || depth !== e.dp) begin
                n_err++; $display("FAIL unf_redir%0d got=%h/%b/%0d exp=%h/%b/%0d", j, pc, flush, depth, e.pc, e.fl, e.dp);
            end
            n_cmp++; if (stk_unf !== (j == 16) || stk_ovf !== 1'b1) begin
                n_err++; $display("FAIL unf_flags%0d got=%b%b exp=1%b", j, stk_ovf, stk_unf, j == 16);
            end
            if (j < 16) begin
                @(negedge clk);
                #1;
                n_cmp++; if (pc !== 11'h201 + 11'(j) || flush !== 1'b0) begin
                    n_err++; $display("FAIL unf_run%0d got=%h/%b exp=%h/0", j, pc, flush, 11'h201 + 11'(j));
                end
            end
        end
        reset = 1'b0;
        #1;
        n_cmp++; if (pc !== 11'h000 || flush !== 1'b1) begin n_err++; $display("FAIL midrst_pc got=%h/%b exp=000/1", pc, flush); end
        n_cmp++; if ({depth, stk_ovf, stk_unf} !== 7'd0) begin n_err++; $display("FAIL midrst_clr got=%h exp=0", {depth, stk_ovf, stk_unf}); end
        @(negedge clk);
        reset = 1'b1;
        sb.push_back(mk(11'h000, 1, 0));
        sb.push_back(mk(11'h001, 0, 0));
        while (sb.size() > 0) begin
            #1;
            e = sb.pop_front();
            n_cmp++; if (pc !== e.pc || flush !== e.fl || depth !== e.dp) begin
                n_err++; $display("FAIL midrst_seq got=%h/%b/%0d exp=%h/%b/%0d", pc, flush, depth, e.pc, e.fl, e.dp);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_call();
        test_ret();
        test_jump_wrap();
        test_skip_stall();
        test_overflow();
        test_underflow_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
